// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state encoding
// and the channel-index width helper.
package edge_event_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_fall_det.sv
// One channel's falling-edge detector: previous-level register plus the
// enable-gated fall pulse. prev resets low so a line low at reset is quiet.
module edge_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign fall = prev & ~sig & en;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects falling edges from N_CH synchronised lines into pending flags and
// hands them one at a time, round-robin, to a single valid/ready consumer.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig_in,
  input  logic [N_CH-1:0]  ch_enable,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_ch,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  pending,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy,
  output logic             fsm_state
);

  // Handshake: evt_valid/evt_ch are held stable from offer until the cycle
  // in which evt_valid && evt_ready; that edge completes the transfer.

  state_e           state, state_next;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  clr;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] pick;
  logic             load;
  logic             done;
  logic             any_drop;

  for (genvar i = 0; i < N_CH; i++) begin : g_det
    edge_fall_det u_det (
      .clk  (clk),
      .rst  (rst),
      .sig  (sig_in[i]),
      .en   (ch_enable[i]),
      .fall (fall[i])
    );
  end

  // Rotate so rr_last+1 sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CH-1:0]  req,
                                               input logic [IDX_W-1:0] last);
    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] shifted;
    logic [N_CH-1:0]   rot;
    int unsigned       sh;
    int unsigned       off;
    dbl     = {req, req};
    sh      = (32'(last) + 32'd1) % 32'(N_CH);
    shifted = dbl >> sh;
    rot     = shifted[N_CH-1:0];
    off     = 0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot[j]) off = 32'(j);
    end
    return IDX_W'((sh + off) % 32'(N_CH));
  endfunction

  assign pick = rr_pick(pending, rr_last);

  always_comb begin
    state_next = state;
    clr        = '0;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          load       = 1'b1;
          clr[pick]  = 1'b1;
          state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A set on a bit being cleared this cycle wins and is not a loss.
  assign any_drop = |(fall & pending & ~clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= '0;
      evt_ch   <= '0;
      rr_last  <= IDX_W'(N_CH - 1);
      drop_cnt <= '0;
    end else begin
      state   <= state_next;
      pending <= fall | (pending & ~clr);
      if (load) evt_ch <= pick;
      if (done) rr_last <= evt_ch;
      if (any_drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign evt_valid = (state == ST_OFFER);
  assign fsm_state = (state == ST_OFFER);
  assign busy      = evt_valid | (|pending);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: edge capture, round-robin order,
// stall stability, drop counting/saturation, channel enable and async reset.
module tb_edge_event_arbiter;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  sig_in;
  logic [N_CH-1:0]  ch_enable;
  logic             evt_valid;
  logic [1:0]       evt_ch;
  logic             evt_ready;
  logic [N_CH-1:0]  pending;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;
  logic             fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .ch_enable (ch_enable),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .pending   (pending),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // checking and driver tasks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the masked lines for one cycle, then drop them: pending is set at
  // the edge that samples the low level.
  task automatic fall_on(input logic [N_CH-1:0] mask);
    sig_in = sig_in | mask;
    tick(1);
    sig_in = sig_in & ~mask;
    tick(1);
  endtask

  // Waits (bounded) for an offer, checks its channel; caller holds ready=1
  // so the following edge completes the handshake.
  task automatic expect_event(input string tag, input int exp_ch);
    int n;
    n = 0;
    while (!evt_valid && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_ch"}, 32'(evt_ch), 32'(exp_ch));
    tick(1);
  endtask

  initial begin
    rst       = 1'b1;
    sig_in    = '0;
    ch_enable = '1;
    evt_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // 1: reset state and single ch0 event
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ch", 32'(evt_ch), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    fall_on(4'b0001);
    check("t1_pend", 32'(pending), 32'b0001);
    check("t1_valid_early", 32'(evt_valid), 32'd0);
    tick(1);
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_ch", 32'(evt_ch), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'd0);
    evt_ready = 1'b1;
    tick(1);
    check("t1_done_valid", 32'(evt_valid), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);

    // 2: round-robin order
    fall_on(4'b1110);
    check("t2_pend", 32'(pending), 32'b1110);
    expect_event("t2_e1", 1);
    expect_event("t2_e2", 2);
    expect_event("t2_e3", 3);
    fall_on(4'b1001);
    expect_event("t2_e4", 0);
    expect_event("t2_e5", 3);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // 3: stall stability, drop on pending ch, re-pend on offered ch
    evt_ready = 1'b0;
    fall_on(4'b0010);
    tick(1);
    fall_on(4'b0100);
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_valid", 32'(evt_valid), 32'd1);
      check("t3_stall_ch", 32'(evt_ch), 32'd1);
      tick(1);
    end
    fall_on(4'b0100);
    check("t3_drop1", 32'(drop_cnt), 32'd1);
    fall_on(4'b0010);
    check("t3_repend", 32'(pending), 32'b0110);
    check("t3_no_drop", 32'(drop_cnt), 32'd1);
    evt_ready = 1'b1;
    expect_event("t3_e1", 1);
    expect_event("t3_e2", 2);
    expect_event("t3_e3", 1);

    // 4: drop counter saturation
    evt_ready = 1'b0;
    fall_on(4'b0001);
    tick(1);
    fall_on(4'b0100);
    for (int i = 0; i < 253; i++) fall_on(4'b0100);
    check("t4_drop254", 32'(drop_cnt), 32'd254);
    for (int i = 0; i < 47; i++) fall_on(4'b0100);
    check("t4_drop_sat", 32'(drop_cnt), 32'd255);
    evt_ready = 1'b1;
    expect_event("t4_e1", 0);
    expect_event("t4_e2", 2);
    check("t4_busy", 32'(busy), 32'd0);

    // 5: channel enable gating
    ch_enable = 4'b1101;
    fall_on(4'b0010);
    tick(3);
    check("t5_dis_pend", 32'(pending), 32'd0);
    check("t5_dis_valid", 32'(evt_valid), 32'd0);
    ch_enable = 4'b1111;
    evt_ready = 1'b0;
    fall_on(4'b0001);
    tick(1);
    fall_on(4'b0100);
    ch_enable = 4'b1011;
    tick(2);
    check("t5_retain", 32'(pending), 32'b0100);
    evt_ready = 1'b1;
    expect_event("t5_e1", 0);
    expect_event("t5_e2", 2);
    ch_enable = 4'b1111;

    // 6: async reset mid-offer
    evt_ready = 1'b0;
    fall_on(4'b1000);
    tick(1);
    fall_on(4'b0001);
    check("t6_pre_valid", 32'(evt_valid), 32'd1);
    check("t6_pre_ch", 32'(evt_ch), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_ch", 32'(evt_ch), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("t6_post_valid", 32'(evt_valid), 32'd0);
    check("t6_post_pend", 32'(pending), 32'd0);
    evt_ready = 1'b1;
    fall_on(4'b1001);
    expect_event("t6_e1", 0);
    expect_event("t6_e2", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
